// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: iterative shift-add WIDTH x WIDTH multiplier with start/busy/done and signed mode
module seq_multiplier_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] mcand, mplr;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0] cnt;
    logic neg, last;
    always_comb begin
        last = cnt == CW'(WIDTH-1);
        acc_nx = acc + (mplr[0] ? {{WIDTH{1'b0}}, mcand} << cnt : '0);
        state_nx = state == IDLE ? (start ? CALC : IDLE) :
                   state == CALC ? (last ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge clk)
        state <= areset ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (areset) begin
            mcand <= '0;
            mplr <= '0;
            acc <= '0;
            cnt <= '0;
            neg <= 1'b0;
            product <= '0;
        end else if (state == IDLE && start) begin
            mcand <= is_signed && A[WIDTH-1] ? -A : A;
            mplr <= is_signed && B[WIDTH-1] ? -B : B;
            neg <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            acc <= acc_nx;
            mplr <= mplr >> 1;
            cnt <= cnt + 1'b1;
            if (last) product <= neg ? -acc_nx : acc_nx;
        end
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule
